// File: rtl/plusarg_decoder_if.sv
// rtl/plusarg_decoder_if.sv - byte-in / value-out stream bundle for the plusarg decoder
interface plusarg_decoder_if #(
  parameter int DATA_W = 32
);
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              err;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, err
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, err
  );
endinterface

// File: rtl/plusarg_decoder.sv
// rtl/plusarg_decoder.sv - parses "+KEY=HEX\n" lines and emits the value of the matching key
module plusarg_decoder #(
  parameter int                    KEY_LEN   = 4,
  parameter logic [8*KEY_LEN-1:0]  MATCH_KEY = "TEST",
  parameter int                    DATA_W    = 32
) (
  input logic             clk,
  input logic             reset,
  plusarg_decoder_if.slave bus
);

  localparam int MAXD = DATA_W / 4;
  localparam int DW   = $clog2(MAXD + 1);

  localparam logic [DW-1:0] MAXD_V    = DW'(MAXD);
  localparam logic [3:0]    KEY_LEN_V = 4'(KEY_LEN);
  localparam logic [3:0]    KEY_SAT   = 4'(KEY_LEN + 1);

  localparam logic [7:0] CH_PLUS = 8'h2B;
  localparam logic [7:0] CH_EQ   = 8'h3D;
  localparam logic [7:0] CH_NL   = 8'h0A;

  typedef enum logic [1:0] {IDLE, KEY, VALUE, SKIP} state_t;

  state_t            state, state_n;
  logic [3:0]        key_idx, key_idx_n;
  logic              key_ok, key_ok_n;
  logic [DATA_W-1:0] acc, acc_n;
  logic [DW-1:0]     digits, digits_n;
  logic [DATA_W-1:0] out_data_r, out_data_n;
  logic              out_valid_r, out_valid_n;
  logic              err_r, err_n;

  logic              in_ready_w;
  logic              accept;
  logic              hex_ok;
  logic [3:0]        nibble;
  logic [7:0]        key_char;

  // Input stalls only while a result is pending and downstream is not taking it.
  assign in_ready_w   = !out_valid_r || bus.out_ready;
  assign accept       = bus.in_valid && in_ready_w;
  assign bus.in_ready = in_ready_w;
  assign bus.out_data = out_data_r;
  assign bus.out_valid = out_valid_r;
  assign bus.err      = err_r;

  // Case-insensitive ASCII hex digit to nibble.
  always_comb begin
    hex_ok = 1'b1;
    nibble = 4'h0;
    if (bus.in_data >= 8'h30 && bus.in_data <= 8'h39) begin
      nibble = bus.in_data[3:0];
    end else if ((bus.in_data >= 8'h61 && bus.in_data <= 8'h66) ||
                 (bus.in_data >= 8'h41 && bus.in_data <= 8'h46)) begin
      nibble = bus.in_data[3:0] + 4'd9;
    end else begin
      hex_ok = 1'b0;
    end
  end

  // Key character expected at the current key position (first char is the MSB byte).
  always_comb begin
    key_char = 8'h00;
    for (int i = 0; i < KEY_LEN; i++) begin
      if (key_idx == 4'(i)) key_char = MATCH_KEY[8*(KEY_LEN-1-i) +: 8];
    end
  end

  // Next-state and datapath updates; nothing moves except on an accepted byte.
  always_comb begin
    state_n     = state;
    key_idx_n   = key_idx;
    key_ok_n    = key_ok;
    acc_n       = acc;
    digits_n    = digits;
    out_data_n  = out_data_r;
    out_valid_n = out_valid_r;
    err_n       = 1'b0;

    if (out_valid_r && bus.out_ready) out_valid_n = 1'b0;

    if (accept) begin
      case (state)
        IDLE: begin
          if (bus.in_data == CH_PLUS) begin
            state_n   = KEY;
            key_idx_n = 4'd0;
            key_ok_n  = 1'b1;
          end else if (bus.in_data != CH_NL) begin
            err_n   = 1'b1;
            state_n = SKIP;
          end
        end
        KEY: begin
          if (bus.in_data == CH_EQ) begin
            if (key_ok && key_idx == KEY_LEN_V) begin
              state_n  = VALUE;
              acc_n    = '0;
              digits_n = '0;
            end else begin
              state_n = SKIP;
            end
          end else if (bus.in_data == CH_NL) begin
            err_n   = 1'b1;
            state_n = IDLE;
          end else begin
            if (key_idx < KEY_LEN_V) key_ok_n = key_ok && (bus.in_data == key_char);
            else                     key_ok_n = 1'b0;
            if (key_idx != KEY_SAT) key_idx_n = key_idx + 4'd1;
          end
        end
        VALUE: begin
          if (hex_ok) begin
            if (digits < MAXD_V) begin
              acc_n    = (acc << 4) | DATA_W'(nibble);
              digits_n = digits + 1'b1;
            end else begin
              err_n   = 1'b1;
              state_n = SKIP;
            end
          end else if (bus.in_data == CH_NL) begin
            state_n = IDLE;
            if (digits != '0) begin
              out_data_n  = acc;
              out_valid_n = 1'b1;
            end else begin
              err_n = 1'b1;
            end
          end else begin
            err_n   = 1'b1;
            state_n = SKIP;
          end
        end
        SKIP: begin
          if (bus.in_data == CH_NL) state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // State and datapath registers; reset drops partial lines and any pending result.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      key_idx     <= 4'd0;
      key_ok      <= 1'b0;
      acc         <= '0;
      digits      <= '0;
      out_data_r  <= '0;
      out_valid_r <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      state       <= state_n;
      key_idx     <= key_idx_n;
      key_ok      <= key_ok_n;
      acc         <= acc_n;
      digits      <= digits_n;
      out_data_r  <= out_data_n;
      out_valid_r <= out_valid_n;
      err_r       <= err_n;
    end
  end

endmodule
